// File: rtl/bcd_display_scan.sv
// bcd_display_scan: four-digit BCD display buffer with time-multiplexed
// scanning of a common-anode 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks positions that have not
// been loaded yet (position 0 is always shown).
module bcd_display_scan #(
    parameter int unsigned DIV_W = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       load,
    input  logic       clear,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic [2:0] digit_cnt,
    output logic       err
);

    logic [15:0]      disp_q, disp_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [DIV_W-1:0] pre_q;
    logic [1:0]       idx_q;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       cur_digit;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD values show "E".
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        unique case (d)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h06;
        endcase
    endfunction

    // Buffer, digit count and error flag next state; clear beats load.
    always_comb begin
        disp_d = disp_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (clear) begin
            disp_d = 16'h0000;
            cnt_d  = 3'd0;
            err_d  = 1'b0;
        end else if (load) begin
            disp_d = {disp_q[11:0], digit_in};
            cnt_d  = (cnt_q >= 3'd4) ? 3'd4 : cnt_q + 3'd1;
            if (digit_in > 4'd9) begin
                err_d = 1'b1;
            end
        end
    end

    // Anode and segment drive for the position currently being scanned.
    always_comb begin
        cur_digit = disp_q[{idx_q, 2'b00} +: 4];
        an_d      = ~(4'b0001 << idx_q);
        seg_d     = seg_decode(cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_q != 2'd0) && ({1'b0, idx_q} >= cnt_q)) begin
            seg_d = 7'h7F;
        end
`endif
    end

    // State registers; prescaler wrap advances the scan index on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= 16'h0000;
            cnt_q  <= 3'd0;
            err_q  <= 1'b0;
            pre_q  <= '0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1111;
            seg_q  <= 7'h7F;
        end else begin
            disp_q <= disp_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            pre_q  <= pre_q + 1'b1;
            if (pre_q == '1) begin
                idx_q <= idx_q + 2'd1;
            end
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign digit_cnt = cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan with DIV_W = 2: directed scenarios plus random
// traffic, every cycle compared against a digit-list / tick-count model.
module tb_bcd_display_scan;

    localparam int DIV_W = 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_in;
    logic       load;
    logic       clear;
    logic [3:0] an;
    logic [6:0] seg;
    logic [2:0] digit_cnt;
    logic       err;

    int checks = 0;
    int errors = 0;

    // Model: digits[0] is newest; tick counts edges since reset.
    int          m_dig[4];
    int          m_cnt;
    bit          m_err;
    int          m_tick;
    logic [6:0]  seg_tab[10];

    bcd_display_scan #(.DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .digit_in  (digit_in),
        .load      (load),
        .clear     (clear),
        .an        (an),
        .seg       (seg),
        .digit_cnt (digit_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] model_seg(input int v);
        if (v <= 9) return seg_tab[v];
        return 7'h06;
    endfunction

    // One clock: drive inputs, advance model, compare all outputs.
    task automatic step(input bit r, input bit ld, input bit cl, input logic [3:0] d);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int         idx;
        rst = r; load = ld; clear = cl; digit_in = d;
        @(posedge clk);
        if (r) begin
            exp_an  = 4'b1111;
            exp_seg = 7'h7F;
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
            m_cnt  = 0;
            m_err  = 1'b0;
            m_tick = 0;
        end else begin
            idx     = (m_tick / (1 << DIV_W)) % 4;
            exp_an  = 4'b1111;
            exp_an[idx] = 1'b0;
            exp_seg = model_seg(m_dig[idx]);
            if (BLANK && idx != 0 && idx >= m_cnt) exp_seg = 7'h7F;
            m_tick++;
            if (cl) begin
                for (int i = 0; i < 4; i++) m_dig[i] = 0;
                m_cnt = 0;
                m_err = 1'b0;
            end else if (ld) begin
                for (int i = 3; i > 0; i--) m_dig[i] = m_dig[i-1];
                m_dig[0] = int'(d);
                if (m_cnt < 4) m_cnt++;
                if (d > 4'd9) m_err = 1'b1;
            end
        end
        #1;
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("digit_cnt", 32'(digit_cnt), 32'(m_cnt));
        check("err", 32'(err), 32'(m_err));
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic ld(input logic [3:0] d);
        step(1'b0, 1'b1, 1'b0, d);
    endtask

    // Idle at least one cycle, then until the given anode is active (bounded).
    task automatic wait_an(input logic [3:0] target);
        int n = 0;
        idle();
        while (an !== target && n < 20) begin
            idle();
            n++;
        end
        if (an !== target) check("wait_an", 32'(an), 32'(target));
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        rst = 1'b1; load = 1'b0; clear = 1'b0; digit_in = 4'd0;
        m_cnt = 0; m_err = 1'b0; m_tick = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        @(negedge clk);

        // Reset and release.
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        check("rst_an", 32'(an), 32'h0F);
        check("rst_seg", 32'(seg), 32'h7F);
        idle();
        check("rel_an", 32'(an), 32'hE);
        check("rel_seg", 32'(seg), 32'h40);

        // Idle scan: 4 cycles per position.
        for (int n = 2; n <= 17; n++) begin
            idle();
            if (n == 4)  check("scan4", 32'(an), 32'hE);
            if (n == 5)  check("scan5", 32'(an), 32'hD);
            if (n == 9)  check("scan9", 32'(an), 32'hB);
            if (n == 13) check("scan13", 32'(an), 32'h7);
            if (n == 17) check("scan17", 32'(an), 32'hE);
        end

        // Load 3 then 7.
        ld(4'd3);
        ld(4'd7);
        check("cnt2", 32'(digit_cnt), 32'd2);
        wait_an(4'hE); check("ld_p0", 32'(seg), 32'h78);
        wait_an(4'hD); check("ld_p1", 32'(seg), 32'h30);
        wait_an(4'hB); check("ld_p2", 32'(seg), BLANK ? 32'h7F : 32'h40);
        wait_an(4'h7); check("ld_p3", 32'(seg), BLANK ? 32'h7F : 32'h40);

        // Overflow: 1..5, digit 1 lost.
        step(1'b0, 1'b0, 1'b1, 4'd0);
        for (int v = 1; v <= 5; v++) ld(4'(v));
        check("cnt4", 32'(digit_cnt), 32'd4);
        wait_an(4'h7); check("ov_p3", 32'(seg), 32'h24);
        wait_an(4'hB); check("ov_p2", 32'(seg), 32'h30);
        wait_an(4'hD); check("ov_p1", 32'(seg), 32'h19);
        wait_an(4'hE); check("ov_p0", 32'(seg), 32'h12);

        // Error flag.
        step(1'b0, 1'b0, 1'b1, 4'd0);
        ld(4'hC);
        check("err_set", 32'(err), 32'd1);
        wait_an(4'hE); check("err_seg", 32'(seg), 32'h06);
        ld(4'd2);
        ld(4'd4);
        check("err_sticky", 32'(err), 32'd1);
        step(1'b0, 1'b0, 1'b1, 4'd0);
        check("err_clr", 32'(err), 32'd0);

        // Simultaneous strobes.
        ld(4'd5);
        step(1'b0, 1'b1, 1'b1, 4'd9);
        check("ldclr_cnt", 32'(digit_cnt), 32'd0);
        wait_an(4'hE); check("ldclr_seg", 32'(seg), 32'h40);
        ld(4'd6);
        step(1'b1, 1'b1, 1'b0, 4'd5);
        check("rstld_cnt", 32'(digit_cnt), 32'd0);
        check("rstld_an", 32'(an), 32'hF);
        check("rstld_seg", 32'(seg), 32'h7F);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
